// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending writes per architectural register and
// stalls issue on RAW/WAW hazards, with same-cycle writeback bypass.
module reg_scoreboard #(
  parameter int unsigned ADDR_BITS = 5,
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned STALL_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic [ADDR_BITS-1:0] issue_rd,
  input  logic [ADDR_BITS-1:0] issue_rs1,
  input  logic [ADDR_BITS-1:0] issue_rs2,
  input  logic [ADDR_BITS-1:0] issue_rs3,
  output logic                 issue_ready,
  input  logic                 wb_valid,
  input  logic [ADDR_BITS-1:0] wb_rd,
  input  logic                 flush,
  output logic [NUM_REGS-1:0]  busy_vec,
  output logic [ADDR_BITS:0]   inflight_cnt,
  output logic [STALL_W-1:0]   stall_cnt,
  output logic                 wb_err
);

  logic [NUM_REGS-1:0] wb_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] eff_busy;
  logic [NUM_REGS-1:0] busy_d;
  logic [ADDR_BITS:0]  inflight_d;
  logic                issue_fire;
  logic                wb_bad;
  logic                stall_inc;

  // Index 0 is excluded from both masks, so bit 0 can never become busy.
  always_comb begin
    wb_mask = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      wb_mask[i] = wb_valid && (wb_rd == ADDR_BITS'(i));
    end
  end

  always_comb begin
    set_mask = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      set_mask[i] = issue_fire && (issue_rd == ADDR_BITS'(i));
    end
  end

  assign eff_busy    = busy_vec & ~wb_mask;
  assign issue_ready = !flush && !eff_busy[issue_rs1] && !eff_busy[issue_rs2] &&
                       !eff_busy[issue_rs3] && !eff_busy[issue_rd];
  assign issue_fire  = issue_valid && issue_ready;

  // Set is applied after clear so a same-cycle set/clear leaves the bit set.
  always_comb begin
    busy_d = '0;
    if (!flush) begin
      busy_d = (busy_vec & ~wb_mask) | set_mask;
    end
  end

  always_comb begin
    inflight_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      inflight_d = inflight_d + {{ADDR_BITS{1'b0}}, busy_d[i]};
    end
  end

  assign wb_bad    = wb_valid && (wb_rd != '0) && !busy_vec[wb_rd];
  assign stall_inc = issue_valid && !issue_ready && !flush && (stall_cnt != '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_vec     <= '0;
      inflight_cnt <= '0;
      stall_cnt    <= '0;
      wb_err       <= 1'b0;
    end else begin
      busy_vec     <= busy_d;
      inflight_cnt <= inflight_d;
      if (stall_inc) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end
      if (wb_bad) begin
        wb_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: directed vectors push expected values,
// a monitor pops and compares them when their due cycle is reached.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0, issue_rs1 = '0, issue_rs2 = '0, issue_rs3 = '0;
  logic        issue_ready;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        flush = 1'b0;
  logic [31:0] busy_vec;
  logic [5:0]  inflight_cnt;
  logic [3:0]  stall_cnt;
  logic        wb_err;

  reg_scoreboard #(
    .ADDR_BITS(5),
    .NUM_REGS (32),
    .STALL_W  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_rs3   (issue_rs3),
    .issue_ready (issue_ready),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .flush       (flush),
    .busy_vec    (busy_vec),
    .inflight_cnt(inflight_cnt),
    .stall_cnt   (stall_cnt),
    .wb_err      (wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          cr;
    bit          cs;
    string       name;
    logic        er;
    logic [31:0] eb;
    logic [5:0]  ei;
    logic [3:0]  es;
    logic        ee;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  event sample_now;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] bm(input int a);
    logic [31:0] one;
    one = 32'd1;
    return one << a;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: checks every expectation whose due cycle has arrived.
  always begin
    exp_t e;
    @(negedge clk or sample_now);
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      if (e.cr) cmp({e.name, ".ready"}, 32'(issue_ready), 32'(e.er));
      if (e.cs) begin
        cmp({e.name, ".busy"}, busy_vec, e.eb);
        cmp({e.name, ".inflight"}, 32'(inflight_cnt), 32'(e.ei));
        cmp({e.name, ".stall"}, 32'(stall_cnt), 32'(e.es));
        cmp({e.name, ".wb_err"}, 32'(wb_err), 32'(e.ee));
      end
    end
  end

  task automatic push(input int due, input bit cr, input bit cs, input string nm,
                      input logic er, input logic [31:0] eb, input int ei, input int es,
                      input logic ee);
    exp_t e;
    e.due = due; e.cr = cr; e.cs = cs; e.name = nm;
    e.er = er; e.eb = eb; e.ei = 6'(ei); e.es = 4'(es); e.ee = ee;
    q.push_back(e);
  endtask

  // One cycle of stimulus: ready is due this cycle, state is due after the edge.
  task automatic step(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rs3, input logic wv,
                      input logic [4:0] wr, input logic fl, input logic er,
                      input logic [31:0] eb, input int ei, input int es, input logic ee,
                      input string nm);
    issue_valid = v; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2; issue_rs3 = rs3;
    wb_valid = wv; wb_rd = wr; flush = fl;
    push(cyc, 1'b1, 1'b0, nm, er, '0, 0, 0, 1'b0);
    push(cyc + 1, 1'b0, 1'b1, nm, 1'b0, eb, ei, es, ee);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    push(cyc, 1'b1, 1'b1, "reset", 1'b1, '0, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, '0, 0, 0, 0, "x0");

    step(1, 5, 0, 0, 0, 0, 0, 0, 1, bm(5), 1, 0, 0, "raw_set");
    step(1, 0, 5, 0, 0, 0, 0, 0, 0, bm(5), 1, 1, 0, "raw_stall");
    step(1, 0, 5, 0, 0, 1, 5, 0, 1, '0, 0, 1, 0, "raw_bypass");

    step(1, 7, 0, 0, 0, 0, 0, 0, 1, bm(7), 1, 1, 0, "waw_set");
    step(1, 7, 0, 0, 0, 1, 7, 0, 1, bm(7), 1, 1, 0, "set_wins");
    step(1, 7, 0, 0, 0, 0, 0, 0, 0, bm(7), 1, 2, 0, "waw_stall");
    step(0, 7, 0, 0, 0, 0, 0, 0, 0, bm(7), 1, 2, 0, "ready_no_valid");
    step(1, 0, 0, 7, 0, 0, 0, 0, 0, bm(7), 1, 3, 0, "rs2_stall");
    step(1, 0, 0, 0, 7, 0, 0, 0, 0, bm(7), 1, 4, 0, "rs3_stall");
    step(0, 0, 0, 0, 0, 1, 7, 0, 1, '0, 0, 4, 0, "wb_clear");

    step(1, 3, 0, 0, 0, 0, 0, 0, 1, bm(3), 1, 4, 0, "fl_set3");
    step(1, 9, 0, 0, 0, 0, 0, 0, 1, bm(3) | bm(9), 2, 4, 0, "fl_set9");
    step(1, 31, 0, 0, 0, 0, 0, 0, 1, bm(3) | bm(9) | bm(31), 3, 4, 0, "fl_set31");
    step(1, 4, 0, 0, 0, 0, 0, 1, 0, '0, 0, 4, 0, "flush");

    step(0, 0, 0, 0, 0, 1, 12, 0, 1, '0, 0, 4, 1, "wb_err_set");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, '0, 0, 4, 1, "wb_err_sticky");

    step(1, 5, 0, 0, 0, 0, 0, 0, 1, bm(5), 1, 4, 1, "sat_set");
    for (int i = 1; i <= 20; i++) begin
      step(1, 0, 5, 0, 0, 0, 0, 0, 0, bm(5), 1, (4 + i > 15) ? 15 : 4 + i, 1, "sat");
    end

    step(1, 1, 0, 0, 0, 1, 5, 0, 1, bm(1), 1, 15, 1, "ar_set1");
    step(1, 2, 0, 0, 0, 0, 0, 0, 1, bm(1) | bm(2), 2, 15, 1, "ar_set2");
    step(1, 3, 0, 0, 0, 0, 0, 0, 1, bm(1) | bm(2) | bm(3), 3, 15, 1, "ar_set3");

    // Mid-cycle reset with inputs that would otherwise change state.
    #5;
    rst = 1'b1;
    issue_valid = 1'b1; issue_rd = 5'd4; wb_valid = 1'b1; wb_rd = 5'd12;
    #2;
    push(cyc, 1'b1, 1'b1, "async_rst", 1'b1, '0, 0, 0, 1'b0);
    -> sample_now;
    @(posedge clk);
    #1;
    push(cyc, 1'b1, 1'b1, "rst_hold", 1'b1, '0, 0, 0, 1'b0);
    -> sample_now;
    #1;
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, '0, 0, 0, 0, "post_rst");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, '0, 0, 0, 0, "idle");

    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameters: ADDR_BITS, 5, register index width; NUM_REGS, 32, architectural registers (2**ADDR_BITS); STALL_W, 16, stall counter width.
REQ-002 SHALL use one clock and one reset; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have issue-side ports, fed by the decode register-extraction stage:
- issue_valid  in  1  decoded instruction presented.
- issue_rd  in  ADDR_BITS  destination index (0 = none).
- issue_rs1 / issue_rs2 / issue_rs3  in  ADDR_BITS each  source indices (0 = unused).
- issue_ready  out  1  no hazard; instruction may issue this cycle.
REQ-004 SHALL have writeback and control ports:
- wb_valid  in  1  a writeback retires this cycle.
- wb_rd  in  ADDR_BITS  retiring destination.
- flush  in  1  discard all pending writes.
REQ-005 SHALL have status outputs:
- busy_vec  out  NUM_REGS  registered pending-write bits.
- inflight_cnt  out  ADDR_BITS+1  number of set busy bits.
- stall_cnt  out  STALL_W  saturating count of stalled cycles.
- wb_err  out  1  sticky flag: writeback to a non-busy register.

Function
REQ-006 SHALL hold one busy bit per register; bit 0 is constant 0 and is never set.
REQ-007 SHALL define eff_busy[i] = busy_vec[i] AND NOT (wb_valid AND wb_rd==i AND i!=0), i.e. same-cycle writeback bypass.
REQ-008 SHALL drive issue_ready combinationally = NOT flush AND NOT eff_busy[rs1] AND NOT eff_busy[rs2] AND NOT eff_busy[rs3] AND NOT eff_busy[rd] (RAW and WAW stall); index 0 never stalls.
REQ-009 SHALL assert issue_ready regardless of issue_valid (ready does not depend on valid).
REQ-010 SHALL treat issue_fire = issue_valid AND issue_ready; on fire with rd!=0, busy_vec[rd] is set at the next edge.
REQ-011 SHALL clear busy_vec[wb_rd] at the next edge when wb_valid and wb_rd!=0.
REQ-012 SHALL, when fire sets and writeback clears the same index in one cycle, leave the bit set (set wins).
REQ-013 SHALL set wb_err at the next edge when wb_valid, wb_rd!=0 and busy_vec[wb_rd]==0; wb_err clears only on reset.
REQ-014 SHALL, on flush, clear all busy bits at the next edge; flush overrides same-cycle set and clear; issue_ready is 0 during flush.
REQ-015 SHALL update inflight_cnt every edge to popcount of the next busy_vec (registered, consistent with busy_vec).
REQ-016 SHALL increment stall_cnt at each edge where issue_valid=1 and issue_ready=0 and flush=0, saturating at 2**STALL_W-1.
REQ-017 SHALL have zero-cycle issue latency (ready same cycle) and one-cycle set/clear latency into busy_vec.

Reset
REQ-018 SHALL, on rst asserted at any time including mid-operation, immediately clear busy_vec, inflight_cnt, stall_cnt and wb_err to 0; issue_ready is then 1.
REQ-019 SHALL ignore issue and writeback inputs while rst is high.

Verification
REQ-020 RAW: issue rd=5 fires; next cycle issue rs1=5 -> issue_ready=0, stall_cnt increments; wb_rd=5 presented -> issue_ready=1 in that same cycle (bypass), busy_vec[5] ends at 0 unless re-set.
REQ-021 WAW plus set-wins: busy[7]=1; issue rd=7 with wb_rd=7 in the same cycle -> fires, and busy_vec[7]=1, inflight_cnt unchanged after the edge.
REQ-022 x0: issue rd=0, rs1=rs2=rs3=0 repeatedly -> always ready, busy_vec stays 0, inflight_cnt=0.
REQ-023 Flush: busy regs {3,9,31}, then flush with a simultaneous fire rd=4 -> issue_ready=0, and after the edge busy_vec=0 and inflight_cnt=0.
REQ-024 Errors/saturation: wb_rd=12 while busy[12]=0 -> wb_err=1 and stays set; STALL_W=4 and 20 stalled cycles -> stall_cnt=15.
REQ-025 Async reset: assert rst mid-cycle with inflight_cnt=3 -> all outputs clear before the next edge.
